// File: rtl/mario_sprite_ctrl_if.sv
// mario_sprite_ctrl_if: motion inputs, scan position, ROM port and pixel outputs of the Mario sprite controller.
interface mario_sprite_ctrl_if;
   logic        frame_tick;
   logic        move_left;
   logic        move_right;
   logic        airborne;
   logic [9:0]  MarioX;
   logic [9:0]  MarioY;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic [10:0] rom_addr;
   logic [23:0] rom_data;
   logic        sprite_on;
   logic [23:0] sprite_rgb;
   logic [2:0]  frame_idx;
   modport master (
      output frame_tick, move_left, move_right, airborne, MarioX, MarioY, DrawX, DrawY, rom_data,
      input  rom_addr, sprite_on, sprite_rgb, frame_idx
   );
   modport slave (
      input  frame_tick, move_left, move_right, airborne, MarioX, MarioY, DrawX, DrawY, rom_data,
      output rom_addr, sprite_on, sprite_rgb, frame_idx
   );
endinterface

// File: rtl/mario_sprite_ctrl.sv
// mario_sprite_ctrl: per-frame motion/animation sequencer and 3-stage sprite ROM pixel fetch.
module mario_sprite_ctrl #(
   parameter int unsigned ANI_DIV     = 6,
   parameter logic [23:0] TRANSPARENT = 24'hFF00FF
) (
   input logic Clk,
   input logic Reset_n,
   mario_sprite_ctrl_if.slave bus
);
   typedef enum logic [1:0] {STAND, WALK, JUMP} state_t;
   state_t      state_q, state_d;
   logic        facing_q, facing_d;
   logic [1:0]  walk_q, walk_d;
   logic [3:0]  div_q, div_d;
   logic [2:0]  frame_q, frame_d;
   logic [10:0] addr_q, addr_d;
   logic        in_d1_q, in_d2_q, on_q;
   logic [23:0] rgb_q;
   logic        div_wrap, in_box, opaque;
   logic [3:0]  rel_x, rel_y, col;
   always_comb begin
      state_d  = bus.airborne ? JUMP : (bus.move_left ^ bus.move_right) ? WALK : STAND;
      div_wrap = div_q == 4'(ANI_DIV - 1);
      walk_d   = state_q != WALK ? 2'd1 : div_wrap ? (walk_q == 2'd3 ? 2'd1 : walk_q + 2'd1) : walk_q;
      div_d    = (state_q != WALK || div_wrap) ? 4'd0 : div_q + 4'd1;
      facing_d = (bus.move_left & ~bus.move_right) ? 1'b1 :
                 (bus.move_right & ~bus.move_left) ? 1'b0 : facing_q;
      frame_d  = state_d == JUMP ? 3'd4 : state_d == WALK ? {1'b0, walk_d} : 3'd0;
      // 11-bit bounds so a sprite near X=1023 cannot wrap its right edge
      in_box   = {1'b0, bus.DrawX} >= {1'b0, bus.MarioX} && {1'b0, bus.DrawX} < {1'b0, bus.MarioX} + 11'd16 &&
                 {1'b0, bus.DrawY} >= {1'b0, bus.MarioY} && {1'b0, bus.DrawY} < {1'b0, bus.MarioY} + 11'd16;
      rel_x    = bus.DrawX[3:0] - bus.MarioX[3:0];
      rel_y    = bus.DrawY[3:0] - bus.MarioY[3:0];
      col      = facing_q ? 4'd15 - rel_x : rel_x;
      addr_d   = in_box ? {frame_q, rel_y, col} : 11'd0;
      opaque   = in_d2_q && bus.rom_data != TRANSPARENT;
   end
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= STAND;
         facing_q <= 1'b0;
         walk_q   <= 2'd1;
         div_q    <= 4'd0;
         frame_q  <= 3'd0;
         addr_q   <= 11'd0;
         in_d1_q  <= 1'b0;
         in_d2_q  <= 1'b0;
         on_q     <= 1'b0;
         rgb_q    <= 24'd0;
      end else begin
         if (bus.frame_tick) begin
            state_q  <= state_d;
            facing_q <= facing_d;
            frame_q  <= frame_d;
            if (state_d == WALK) begin
               walk_q <= walk_d;
               div_q  <= div_d;
            end
         end
         addr_q  <= addr_d;
         in_d1_q <= in_box;
         in_d2_q <= in_d1_q;
         on_q    <= opaque;
         rgb_q   <= opaque ? bus.rom_data : 24'd0;
      end
   end
   assign bus.rom_addr   = addr_q;
   assign bus.sprite_on  = on_q;
   assign bus.sprite_rgb = rgb_q;
   assign bus.frame_idx  = frame_q;
endmodule

// File: tb/tb_mario_sprite_ctrl.sv
// tb_mario_sprite_ctrl: directed vectors with literal expectations plus a per-cycle behavioural model compare.
module tb_mario_sprite_ctrl;
   localparam int ANI_DIV = 2;
   localparam int TR = 24'hFF00FF;
   logic Clk, Reset_n;
   logic [23:0] rom_mem [0:2047];
   int checks = 0, errors = 0;
   int mode = 0, facing = 0, walk_n = 0, mframe = 0;
   int h_in1 = 0, h_in2 = 0, h_a1 = 0, h_a2 = 0;
   int seq [7] = '{1, 1, 2, 2, 3, 3, 1};
   mario_sprite_ctrl_if bus();
   mario_sprite_ctrl #(.ANI_DIV(ANI_DIV), .TRANSPARENT(24'hFF00FF)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave)
   );
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) bus.rom_data <= rom_mem[bus.rom_addr];
   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask
   // Model: animation from tick counts, address from plain pixel geometry, outputs from 2-edge-old fetches
   initial forever begin
      int dx, dy, mx, my, in_k, a_k, nm, rx, ry, exp_on;
      @(posedge Clk);
      #1;
      if (!Reset_n) begin
         mode = 0; facing = 0; walk_n = 0; mframe = 0;
         h_in1 = 0; h_in2 = 0; h_a1 = 0; h_a2 = 0;
         check("rst_on", int'(bus.sprite_on), 0);
         check("rst_rgb", int'(bus.sprite_rgb), 0);
         check("rst_addr", int'(bus.rom_addr), 0);
         check("rst_frame", int'(bus.frame_idx), 0);
      end else begin
         dx = int'(bus.DrawX); dy = int'(bus.DrawY); mx = int'(bus.MarioX); my = int'(bus.MarioY);
         in_k = (dx >= mx && dx < mx + 16 && dy >= my && dy < my + 16) ? 1 : 0;
         rx = dx - mx; ry = dy - my;
         a_k = in_k ? mframe * 256 + ry * 16 + (facing ? 15 - rx : rx) : 0;
         if (bus.frame_tick) begin
            nm = bus.airborne ? 2 : (bus.move_left != bus.move_right) ? 1 : 0;
            if (nm == 1) walk_n = (mode == 1) ? walk_n + 1 : 0;
            mframe = nm == 2 ? 4 : nm == 1 ? 1 + (walk_n / ANI_DIV) % 3 : 0;
            if (bus.move_left && !bus.move_right) facing = 1;
            if (bus.move_right && !bus.move_left) facing = 0;
            mode = nm;
         end
         exp_on = (h_in2 != 0 && int'(rom_mem[h_a2]) != TR) ? 1 : 0;
         check("m_addr", int'(bus.rom_addr), a_k);
         check("m_frame", int'(bus.frame_idx), mframe);
         check("m_on", int'(bus.sprite_on), exp_on);
         check("m_rgb", int'(bus.sprite_rgb), exp_on ? int'(rom_mem[h_a2]) : 0);
         h_in2 = h_in1; h_a2 = h_a1; h_in1 = in_k; h_a1 = a_k;
      end
   end
   task automatic tick();
      @(negedge Clk) bus.frame_tick = 1'b1;
      @(negedge Clk) bus.frame_tick = 1'b0;
   endtask
   task automatic edge_after();
      @(posedge Clk);
      #2;
   endtask
   initial begin
      for (int i = 0; i < 2048; i++) rom_mem[i] = 24'(i * 24'h010305 + 24'h000100);
      rom_mem[83] = 24'h0000FF;
      rom_mem[5]  = 24'hFF00FF;
      Reset_n = 1'b0;
      bus.frame_tick = 1'b0; bus.move_left = 1'b0; bus.move_right = 1'b0; bus.airborne = 1'b0;
      bus.MarioX = 10'd100; bus.MarioY = 10'd200; bus.DrawX = 10'd0; bus.DrawY = 10'd0;
      repeat (3) @(negedge Clk);
      check("init_addr", int'(bus.rom_addr), 0);
      Reset_n = 1'b1; bus.DrawX = 10'd103; bus.DrawY = 10'd205;
      edge_after();
      check("stand_addr", int'(bus.rom_addr), 83);
      edge_after();
      edge_after();
      check("stand_on", int'(bus.sprite_on), 1);
      check("stand_rgb", int'(bus.sprite_rgb), 24'h0000FF);
      @(negedge Clk) Reset_n = 1'b0;
      #1;
      check("async_on", int'(bus.sprite_on), 0);
      check("async_rgb", int'(bus.sprite_rgb), 0);
      check("async_addr", int'(bus.rom_addr), 0);
      check("async_frame", int'(bus.frame_idx), 0);
      @(negedge Clk) Reset_n = 1'b1;
      edge_after();
      edge_after();
      check("post_rst_on_early", int'(bus.sprite_on), 0);
      edge_after();
      check("post_rst_on", int'(bus.sprite_on), 1);
      @(negedge Clk) begin bus.DrawX = 10'd0; bus.move_right = 1'b1; end
      for (int i = 0; i < 7; i++) begin
         tick();
         check($sformatf("walk_seq%0d", i), int'(bus.frame_idx), seq[i]);
      end
      bus.move_right = 1'b0;
      tick();
      check("stand_again", int'(bus.frame_idx), 0);
      bus.move_left = 1'b1; bus.DrawX = 10'd100; bus.DrawY = 10'd200;
      tick();
      check("flip_frame", int'(bus.frame_idx), 1);
      edge_after();
      check("flip_addr", int'(bus.rom_addr), 271);
      @(negedge Clk) bus.move_right = 1'b1;
      tick();
      check("both_frame", int'(bus.frame_idx), 0);
      edge_after();
      check("both_facing_addr", int'(bus.rom_addr), 15);
      @(negedge Clk) begin bus.move_left = 1'b0; bus.airborne = 1'b1; end
      tick();
      check("jump_frame", int'(bus.frame_idx), 4);
      edge_after();
      check("jump_addr", int'(bus.rom_addr), 1024);
      @(negedge Clk) begin bus.airborne = 1'b0; bus.move_right = 1'b0; end
      tick();
      bus.MarioX = 10'd630; bus.DrawX = 10'd639;
      edge_after();
      check("edge_right_addr", int'(bus.rom_addr), 9);
      edge_after();
      edge_after();
      check("edge_right_on", int'(bus.sprite_on), 1);
      @(negedge Clk) begin bus.MarioX = 10'd100; bus.DrawX = 10'd99; end
      edge_after();
      check("left_out_addr", int'(bus.rom_addr), 0);
      edge_after();
      edge_after();
      check("left_out_on", int'(bus.sprite_on), 0);
      @(negedge Clk) bus.DrawX = 10'd105;
      edge_after();
      check("transp_addr", int'(bus.rom_addr), 5);
      edge_after();
      edge_after();
      check("transp_on", int'(bus.sprite_on), 0);
      check("transp_rgb", int'(bus.sprite_rgb), 0);
      for (int i = 0; i < 300; i++) begin
         @(negedge Clk);
         bus.DrawX = 10'(95 + i % 30);
         bus.DrawY = 10'(195 + (i / 30) % 25);
         bus.frame_tick = (i % 9 == 0);
         bus.move_left = ((i % 50) >= 25);
         bus.move_right = ((i % 70) < 40);
         bus.airborne = ((i % 111) > 100);
      end
      @(negedge Clk) bus.frame_tick = 1'b0;
      repeat (4) @(negedge Clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mario_sprite_ctrl.md
# mario_sprite_ctrl

Animation sequencer and pixel-fetch controller for the Mario sprite ROM (1280 x 24-bit words: five 16x16 frames, 256 words per frame). It tracks Mario's motion state once per video frame, selects the animation frame and facing direction, and generates the per-pixel ROM read address from the VGA scan position. It returns a registered sprite-hit flag and RGB value to the colour mapper. It sits between the Mario motion logic and the ROM, and owns the ROM's read port.

## Interface
- ANI_DIV, 6: number of frame_tick pulses per walk-cycle frame advance; legal range 1..15.
- TRANSPARENT, 24'hFF00FF: ROM colour treated as "no sprite pixel".

- Clk  in  1  system clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame (start of vertical blank).
- move_left  in  1  level: left input held.
- move_right  in  1  level: right input held.
- airborne  in  1  level: Mario not on ground.
- MarioX  in  10  sprite top-left X, in pixels.
- MarioY  in  10  sprite top-left Y, in pixels.
- DrawX  in  10  current scan X.
- DrawY  in  10  current scan Y.
- rom_addr  out  11  registered read address to the sprite ROM.
- rom_data  in  24  ROM output; valid one cycle after rom_addr.
- sprite_on  out  1  registered: the current pixel is an opaque Mario pixel.
- sprite_rgb  out  24  registered: colour of the pixel; 0 when sprite_on is 0.
- frame_idx  out  3  registered: current animation frame (0..4), for debug.

## Operation
- Frame map:
  - frame 0 = stand.
  - frames 1, 2, 3 = walk cycle.
  - frame 4 = jump.
  - Frame base address = frame_idx * 256.
- Motion state machine (STAND, WALK, JUMP) evaluates only on cycles where frame_tick = 1; it holds otherwise. Next state is decided in priority order:
  - airborne = 1 -> JUMP.
  - else move_left XOR move_right -> WALK.
  - else STAND. This includes both directions held at once.
- Facing register (facing_left) updates on frame_tick:
  - move_left & ~move_right -> 1.
  - move_right & ~move_left -> 0.
  - otherwise hold. The register updates in JUMP as well.
- frame_idx per state: STAND -> 0; JUMP -> 4; WALK -> walk_frame.
- Walk counter (div_cnt, 4 bits) and walk_frame:
  - On entry to WALK from another state: walk_frame = 1, div_cnt = 0.
  - Each frame_tick while staying in WALK: div_cnt increments.
  - When div_cnt = ANI_DIV-1 on a tick: div_cnt wraps to 0 and walk_frame advances 1->2->3->1.
  - With ANI_DIV = 1, the frame advances on every tick.
- Pixel address:
  - rel_x = DrawX - MarioX; rel_y = DrawY - MarioY.
  - in_box = DrawX >= MarioX, DrawX < MarioX+16, DrawY >= MarioY, DrawY < MarioY+16. Both bounds are compared in 11 bits so that MarioX+16 does not wrap.
  - col = facing_left ? 15 - rel_x[3:0] : rel_x[3:0].
  - rom_addr <= frame_idx*256 + rel_y[3:0]*16 + col when in_box; otherwise rom_addr <= 0.
- Output stage: sprite_on <= in_box_d2 & (rom_data != TRANSPARENT); sprite_rgb <= the same condition ? rom_data : 0.
- frame_idx and facing change only on frame_tick. Frame_tick falls in blanking, so a visible frame never mixes two sprite frames.

## Timing
- Reset values, applied asynchronously while Reset_n = 0:
  - state = STAND, facing_left = 0, walk_frame = 1, div_cnt = 0.
  - frame_idx = 0, rom_addr = 0.
  - in_box pipeline = 0, sprite_on = 0, sprite_rgb = 0.
- Pixel latency is 3 cycles from DrawX/DrawY to sprite_on/sprite_rgb:
  - edge 1: rom_addr and in_box_d1 registered.
  - edge 2: ROM data valid, in_box_d2 registered.
  - edge 3: outputs registered.
- The colour mapper must delay DrawX/DrawY by 3 cycles to align with these outputs.
- State update latency: new state and frame_idx are visible the cycle after the frame_tick edge. rom_addr reflects them one cycle later.
- Reset mid-operation:
  - All outputs drop to 0 immediately.
  - The first valid sprite_on is possible 3 cycles after Reset_n rises.
  - Motion state resumes at STAND until the next frame_tick.
- frame_tick held high for several cycles is treated as several ticks; the source must guarantee a single-cycle pulse.

## Test plan
- Reset: assert Reset_n = 0 mid-scan with sprite_on = 1 -> sprite_on = 0, sprite_rgb = 0, rom_addr = 0, frame_idx = 0 in the same cycle.
- Stand fetch:
  - Setup: MarioX = 100, MarioY = 200, no inputs, DrawX = 103, DrawY = 205.
  - Expected: rom_addr = 83 one cycle later.
  - Expected: with rom_data = 24'h0000FF, sprite_on = 1 and sprite_rgb = 24'h0000FF three cycles after the scan position.
- Walk cycle (ANI_DIV = 2): hold move_right and pulse frame_tick 7 times -> frame_idx sequence 1,1,2,2,3,3,1.
- Flip:
  - Setup: move_left held, one tick, frame 1, rel_x = 0, rel_y = 0.
  - Expected: rom_addr = 256 + 15 = 271.
  - Expected: both directions held on the next tick -> STAND, facing_left stays 1.
- Jump priority: airborne = 1 with move_right on a tick -> frame_idx = 4; rom_addr base = 1024.
- Edges:
  - MarioX = 630, DrawX = 639 -> in_box = 1, no wrap.
  - DrawX = 99 with MarioX = 100 -> sprite_on = 0.
  - rom_data = 24'hFF00FF inside the box -> sprite_on = 0, sprite_rgb = 0.
